rx_stack_ctrl: RTL

//  Controller for the photonic receive path and the receive stack.
//  - Registers incoming 32-bit link packets and matches bits [15:0] against the node ID.
//  - Pushes the payload (bits [31:16]) of each matching packet into a single-port LIFO data memory.
//  - Serves pop requests from the core, arbitrating the one memory port between link pushes and core pops.
//  - Owns the rx stack pointer, full/empty flags and a drop counter.

---
 rtl/rx_stack_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rx_stack_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rx_stack_ctrl
// Purpose  : Receive-path controller for the photonic link. Registers incoming
//            link packets, matches the destination ID against this node, pushes
//            matching payloads into a single-port LIFO memory and serves core
//            pop requests over the same memory port. Maintains the stack
//            pointer, full/empty flags and a saturating drop counter.
// Ports    : clk, rst (async, active-low)
//            rx_in/rx_valid        link packet {payload, dest_id}
//            id                    this node's ID (quasi-static)
//            pop_req               one-cycle pop request from the core
//            pop_valid/data/err    pop result, one-cycle pulse
//            mem_en/we/addr/wdata  single-port memory access
//            mem_rdata             registered read data (1-cycle latency)
//            rx_stack_ptr          occupancy 0..DEPTH
//            full, empty           occupancy flags
//            drop_cnt              matching packets dropped while full (sat.)
// Options  : RX_BROADCAST_EN - when defined, dest_id == all-ones also matches.
// Revision : 1.0 - initial release
// ============================================================================
module rx_stack_ctrl #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rx_in,
  input  logic              rx_valid,
  input  logic [ID_W-1:0]   id,
  input  logic              pop_req,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   rx_stack_ptr,
  output logic              full,
  output logic              empty,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_PTR_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RDATA = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_pkt;
  logic              r_pkt_vld;
  logic              r_pop_pend;
  logic [ADDR_W:0]   r_ptr;
  logic [7:0]        r_drop_cnt;

  logic              w_id_match;
  logic              w_match;
  logic              w_push;
  logic              w_drop;
  logic              w_pop_go;
  logic              w_rd;
  logic [ADDR_W:0]   w_ptr_m1;

`ifdef RX_BROADCAST_EN
  assign w_id_match = (r_pkt[ID_W-1:0] == id) || (r_pkt[ID_W-1:0] == {ID_W{1'b1}});
`else
  assign w_id_match = (r_pkt[ID_W-1:0] == id);
`endif

  assign full     = (r_ptr == c_DEPTH);
  assign empty    = (r_ptr == '0);
  assign w_match  = r_pkt_vld && w_id_match;
  assign w_push   = w_match && !full;
  assign w_drop   = w_match && full;
  // The link cannot be stalled, so a push always owns the memory port and a
  // pending pop simply waits in IDLE until a push-free cycle.
  assign w_pop_go = r_pop_pend && (r_state == S_IDLE) && !w_push;
  assign w_rd     = w_pop_go && !empty;
  assign w_ptr_m1 = r_ptr - c_PTR_ONE;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_push) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_ptr[ADDR_W-1:0];
      mem_wdata = r_pkt[ID_W +: DATA_W];
    end else if (w_rd) begin
      mem_en   = 1'b1;
      mem_addr = w_ptr_m1[ADDR_W-1:0];
    end
  end

  // Result outputs are decoded from the state register only. Read data is
  // passed straight from the registered memory output during RDATA.
  assign pop_valid    = (r_state != S_IDLE);
  assign pop_err      = (r_state == S_ERR);
  assign pop_data     = (r_state == S_RDATA) ? mem_rdata : '0;
  assign rx_stack_ptr = r_ptr;
  assign drop_cnt     = r_drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pkt      <= '0;
      r_pkt_vld  <= 1'b0;
      r_pop_pend <= 1'b0;
      r_ptr      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pkt_vld <= rx_valid;
      if (rx_valid) begin
        r_pkt <= rx_in;
      end

      if (w_push) begin
        r_ptr <= r_ptr + c_PTR_ONE;
      end else if (w_rd) begin
        r_ptr <= w_ptr_m1;
      end

      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      // A request arriving while one is pending or in flight is dropped.
      if (w_pop_go) begin
        r_pop_pend <= 1'b0;
      end else if (pop_req && !r_pop_pend && (r_state == S_IDLE)) begin
        r_pop_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop_go) begin
            r_state <= empty ? S_ERR : S_RDATA;
          end
        end
        S_RDATA: r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
